// File: rtl/lfsr32_pkg.sv
// lfsr32 shared definitions: polynomial, word width, checker states
// and the one-step Fibonacci successor next32().
package lfsr32_pkg;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] POLY = 32'h8000_0923;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Taps 31,30,26,23,20,0 are POLY mirrored for a right-shifting register.
  function automatic logic [W-1:0] next32(input logic [W-1:0] w);
    logic fb;
    fb = w[31] ^ w[30] ^ w[26] ^ w[23] ^ w[20] ^ w[0];
    return {fb, w[W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr32_popcnt.sv
// lfsr32_popcnt: 32-bit population count.
// din_i: word, cnt_o: number of set bits (0..32).
module lfsr32_popcnt
  import lfsr32_pkg::*;
(
  input  logic [W-1:0] din_i,
  output logic [5:0]   cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + 6'(din_i[i]);
    end
  end

endmodule

// File: rtl/lfsr32_checker.sv
// lfsr32_checker: PRBS-32 receive checker with hunt/sync/lock and
// flywheel reference; counts word errors while locked.
// Ports: CLK, RST_N (async low), CLR (clear counters), VALID, DIN[31:0]
//        -> LOCKED, ERR (pulse), LOS (pulse), ERR_CNT[ERRW-1:0].
// Macro LFSR32_CHECKER_BITERR_EN adds BIT_ERR_CNT[ERRW-1:0].
module lfsr32_checker
  import lfsr32_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8,
  parameter int unsigned ERRW     = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  input  logic            VALID,
  input  logic [W-1:0]    DIN,
  output logic            LOCKED,
  output logic            ERR,
  output logic            LOS,
  output logic [ERRW-1:0] ERR_CNT
`ifdef LFSR32_CHECKER_BITERR_EN
  ,
  output logic [ERRW-1:0] BIT_ERR_CNT
`endif
);

  localparam logic [7:0] LOCK8 = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS8 = 8'(LOSS_CNT);

  state_e          state_q, state_d;
  logic [W-1:0]    ref_q, ref_d;
  logic [7:0]      mcnt_q, mcnt_d;
  logic [7:0]      miss_q, miss_d;
  logic            locked_q, err_q, los_q;
  logic            err_d, los_d;
  logic [ERRW-1:0] ecnt_q, ecnt_d;
  logic [7:0]      mcnt_inc, miss_inc;
  logic            hit;

  assign hit      = (DIN == ref_q);
  assign mcnt_inc = mcnt_q + 8'd1;
  assign miss_inc = miss_q + 8'd1;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    mcnt_d  = mcnt_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    los_d   = 1'b0;
    if (VALID) begin
      unique case (state_q)
        ST_HUNT: begin
          if (DIN != '0) begin
            ref_d   = next32(DIN);
            mcnt_d  = 8'd1;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (hit) begin
            ref_d  = next32(DIN);
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK8) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (DIN != '0) begin
            ref_d  = next32(DIN);
            mcnt_d = 8'd1;
          end else begin
            state_d = ST_HUNT;
            ref_d   = '0;
            mcnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the reference free-runs, data never reseeds it.
          ref_d = next32(ref_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == LOSS8) begin
              state_d = ST_HUNT;
              los_d   = 1'b1;
              mcnt_d  = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // CLR beats a coincident count.
  always_comb begin
    ecnt_d = ecnt_q;
    if (CLR) begin
      ecnt_d = '0;
    end else if (err_d && (ecnt_q != '1)) begin
      ecnt_d = ecnt_q + ERRW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_HUNT;
      ref_q    <= '0;
      mcnt_q   <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      los_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      mcnt_q   <= mcnt_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == ST_LOCKED);
      err_q    <= err_d;
      los_q    <= los_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign LOCKED  = locked_q;
  assign ERR     = err_q;
  assign LOS     = los_q;
  assign ERR_CNT = ecnt_q;

`ifdef LFSR32_CHECKER_BITERR_EN
  localparam logic [ERRW-1:0] EMAX = '1;

  logic [5:0]      pc;
  logic [ERRW+6:0] bsum;
  logic [ERRW-1:0] becnt_q, becnt_d;

  lfsr32_popcnt u_popcnt (
    .din_i (DIN ^ ref_q),
    .cnt_o (pc)
  );

  // Widened sum so the saturation test cannot itself overflow.
  assign bsum = {7'd0, becnt_q} + {{(ERRW+1){1'b0}}, pc};

  always_comb begin
    becnt_d = becnt_q;
    if (CLR) begin
      becnt_d = '0;
    end else if (err_d) begin
      becnt_d = (bsum > {7'd0, EMAX}) ? EMAX : bsum[ERRW-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) becnt_q <= '0;
    else        becnt_q <= becnt_d;
  end

  assign BIT_ERR_CNT = becnt_q;
`endif

endmodule

// File: tb/tb_lfsr32_checker.sv
// tb_lfsr32_checker: scoreboard bench for lfsr32_checker.
// dut_a: LOCK 4 / LOSS 8 / ERRW 16, dut_b: LOCK 4 / LOSS 255 / ERRW 4.
module tb_lfsr32_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] din = '0;

  logic        lk_a, er_a, ls_a;
  logic [15:0] cnt_a;
  logic        lk_b, er_b, ls_b;
  logic [3:0]  cnt_b;
`ifdef LFSR32_CHECKER_BITERR_EN
  logic [15:0] bcnt_a;
  logic [3:0]  bcnt_b;
`endif

  always #5 clk = ~clk;

  lfsr32_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERRW(16)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .VALID(valid), .DIN(din),
    .LOCKED(lk_a), .ERR(er_a), .LOS(ls_a), .ERR_CNT(cnt_a)
`ifdef LFSR32_CHECKER_BITERR_EN
    , .BIT_ERR_CNT(bcnt_a)
`endif
  );

  lfsr32_checker #(.LOCK_CNT(4), .LOSS_CNT(255), .ERRW(4)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .VALID(valid), .DIN(din),
    .LOCKED(lk_b), .ERR(er_b), .LOS(ls_b), .ERR_CNT(cnt_b)
`ifdef LFSR32_CHECKER_BITERR_EN
    , .BIT_ERR_CNT(bcnt_b)
`endif
  );

  typedef struct packed {
    logic lk; logic er; logic ls; logic [15:0] cnt;
  } oa_t;
  typedef struct packed {
    logic lk; logic er; logic ls; logic [3:0] cnt;
  } ob_t;
  typedef struct packed { oa_t a; ob_t b; } obs_t;
  typedef struct packed { oa_t a; ob_t b; bit usea; bit useb; } exp_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] nx;

  function automatic logic [31:0] tnext(input logic [31:0] w);
    return {w[31] ^ w[30] ^ w[26] ^ w[23] ^ w[20] ^ w[0], w[31:1]};
  endfunction

  // Drive one cycle from a negedge, capture outputs at the next negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic c);
    obs_t o;
    valid = v; din = d; clr = c;
    @(negedge clk);
    o.a = {lk_a, er_a, ls_a, cnt_a};
    o.b = {lk_b, er_b, ls_b, cnt_b};
    obs_q.push_back(o);
  endtask

  task automatic exp_ab(input bit lk, input bit er, input bit ls,
                        input int cnt);
    exp_t e;
    e.a = {lk, er, ls, 16'(cnt)};
    e.b = {lk, er, ls, 4'(cnt)};
    e.usea = 1'b1; e.useb = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic exp_a(input bit lk, input bit er, input bit ls,
                       input int cnt);
    exp_t e;
    e.a = {lk, er, ls, 16'(cnt)};
    e.b = '0;
    e.usea = 1'b1; e.useb = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_b(input bit lk, input bit er, input bit ls,
                       input int cnt);
    exp_t e;
    e.a = '0;
    e.b = {lk, er, ls, 4'(cnt)};
    e.usea = 1'b0; e.useb = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; valid = 1'b0; clr = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic lock_up;
    nx = 32'h1;
    for (int i = 0; i < 4; i++) begin
      exp_ab(i == 3, 1'b0, 1'b0, 0);
      step(1'b1, nx, 1'b0);
      nx = tnext(nx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lk_a, er_a, ls_a, cnt_a, lk_b, er_b, ls_b, cnt_b} !== '0) begin
      errors++;
      $display("FAIL reset got %b %b %b %h / %b %b %b %h exp all 0",
               lk_a, er_a, ls_a, cnt_a, lk_b, er_b, ls_b, cnt_b);
    end
    do_reset();
  endtask

  task automatic test_lock;
    logic [31:0] seq [4];
    exp_t e; obs_t o;
    seq[0] = 32'h0000_0001; seq[1] = 32'h8000_0000;
    seq[2] = 32'hC000_0000; seq[3] = 32'h6000_0000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_ab(i == 3, 1'b0, 1'b0, 0);
      step(1'b1, seq[i], 1'b0);
    end
    nx = tnext(seq[3]);
    for (int i = 0; i < 3; i++) begin
      exp_ab(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, nx, 1'b0);
      nx = tnext(nx);
    end
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL lock[%0d] no output", i);
      end else begin
        o = obs_q.pop_front();
        if ((e.usea && o.a !== e.a) || (e.useb && o.b !== e.b)) begin
          errors++;
          $display("FAIL lock[%0d] got %h/%h exp %h/%h", i, o.a, o.b, e.a, e.b);
        end
      end
    end
  endtask

  task automatic test_hunt_zero;
    exp_t e; obs_t o;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_ab(1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 32'h0, 1'b0);
    end
    lock_up();
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL hunt0[%0d] no output", i);
      end else begin
        o = obs_q.pop_front();
        if ((e.usea && o.a !== e.a) || (e.useb && o.b !== e.b)) begin
          errors++;
          $display("FAIL hunt0[%0d] got %h/%h exp %h/%h", i, o.a, o.b, e.a, e.b);
        end
      end
    end
  endtask

  task automatic test_single_err;
    exp_t e; obs_t o;
    do_reset();
    lock_up();
    exp_ab(1'b1, 1'b1, 1'b0, 1);
    step(1'b1, nx ^ 32'h1, 1'b0);
`ifdef LFSR32_CHECKER_BITERR_EN
    checks++;
    if (bcnt_a !== 16'd1 || bcnt_b !== 4'd1) begin
      errors++;
      $display("FAIL biterr got %h/%h exp 1/1", bcnt_a, bcnt_b);
    end
`endif
    nx = tnext(nx);
    exp_ab(1'b1, 1'b0, 1'b0, 1);
    step(1'b1, nx, 1'b0);
    nx = tnext(nx);
    exp_ab(1'b1, 1'b0, 1'b0, 1);
    step(1'b0, 32'hDEAD_BEEF, 1'b0);
    exp_ab(1'b1, 1'b0, 1'b0, 1);
    step(1'b1, nx, 1'b0);
    nx = tnext(nx);
    exp_ab(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 32'h0, 1'b1);
    exp_ab(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, nx, 1'b0);
    nx = tnext(nx);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL single[%0d] no output", i);
      end else begin
        o = obs_q.pop_front();
        if ((e.usea && o.a !== e.a) || (e.useb && o.b !== e.b)) begin
          errors++;
          $display("FAIL single[%0d] got %h/%h exp %h/%h", i, o.a, o.b, e.a, e.b);
        end
      end
    end
  endtask

  task automatic test_loss;
    exp_t e; obs_t o;
    do_reset();
    lock_up();
    for (int k = 1; k <= 8; k++) begin
      exp_a(k < 8, 1'b1, k == 8, k);
      step(1'b1, nx ^ ($urandom() | 32'h1), 1'b0);
      nx = tnext(nx);
    end
    exp_a(1'b0, 1'b0, 1'b0, 8);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL loss[%0d] no output", i);
      end else begin
        o = obs_q.pop_front();
        if ((e.usea && o.a !== e.a) || (e.useb && o.b !== e.b)) begin
          errors++;
          $display("FAIL loss[%0d] got %h exp %h", i, o.a, e.a);
        end
      end
    end
  endtask

  task automatic test_saturation;
    exp_t e; obs_t o;
    do_reset();
    lock_up();
    for (int k = 1; k <= 20; k++) begin
      exp_b(1'b1, 1'b1, 1'b0, (k > 15) ? 15 : k);
      step(1'b1, nx ^ ($urandom() | 32'h1), 1'b0);
      nx = tnext(nx);
    end
    exp_b(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, nx ^ 32'h8000_0001, 1'b1);
    nx = tnext(nx);
    exp_b(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL sat[%0d] no output", i);
      end else begin
        o = obs_q.pop_front();
        if ((e.usea && o.a !== e.a) || (e.useb && o.b !== e.b)) begin
          errors++;
          $display("FAIL sat[%0d] got %h exp %h", i, o.b, e.b);
        end
      end
    end
  endtask

  task automatic test_reset_midlock;
    exp_t e; obs_t o;
    do_reset();
    lock_up();
    exp_ab(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 32'h1234_5678, 1'b0);
    exp_ab(1'b1, 1'b1, 1'b0, 1);
    step(1'b1, nx ^ 32'h4, 1'b0);
    #1 rst_n = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if ({lk_a, er_a, ls_a, cnt_a, lk_b, er_b, ls_b, cnt_b} !== '0) begin
      errors++;
      $display("FAIL midreset got %b %b %b %h / %b %b %b %h exp all 0",
               lk_a, er_a, ls_a, cnt_a, lk_b, er_b, ls_b, cnt_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nx = 32'h1;
    for (int i = 0; i < 4; i++) begin
      exp_ab(i == 3, 1'b0, 1'b0, 0);
      step(1'b1, nx, 1'b0);
      nx = tnext(nx);
      exp_ab(i == 3, 1'b0, 1'b0, 0);
      step(1'b0, 32'hFFFF_FFFF, 1'b0);
    end
    for (int i = 0; exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL relock[%0d] no output", i);
      end else begin
        o = obs_q.pop_front();
        if ((e.usea && o.a !== e.a) || (e.useb && o.b !== e.b)) begin
          errors++;
          $display("FAIL relock[%0d] got %h/%h exp %h/%h", i, o.a, o.b, e.a, e.b);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock();
    test_hunt_zero();
    test_single_err();
    test_loss();
    test_saturation();
    test_reset_midlock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr32_checker.md
LFSR32_CHECKER -- requirements
Module: lfsr32_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive matching words required to declare lock (range 2..255).
REQ-002 SHALL have parameter LOSS_CNT, default 8: consecutive mismatching words in lock that cause loss of lock (range 1..255).
REQ-003 SHALL have parameter ERRW, default 16: width of the error counter(s).
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port CLR  input  1  synchronous clear of error counters only.
REQ-007 SHALL have port VALID  input  1  DIN qualifier; one received word per cycle with VALID=1.
REQ-008 SHALL have port DIN  input  32  received generator output word.
REQ-009 SHALL have port LOCKED  output  1  high while in LOCKED state.
REQ-010 SHALL have port ERR  output  1  registered one-cycle pulse per mismatching word in LOCKED.
REQ-011 SHALL have port LOS  output  1  registered one-cycle pulse on LOCKED->HUNT transition.
REQ-012 SHALL have port ERR_CNT  output  ERRW  saturating count of mismatching words in LOCKED.

Function
REQ-013 SHALL define next(w) = {fb, w[31:1]}, with fb = w[31]^w[30]^w[26]^w[23]^w[20]^w[0] (polynomial 80000923h, Fibonacci, one step per word).
REQ-014 SHALL implement states HUNT, SYNC, LOCKED plus registers REF[31:0], MCNT, MISS.
REQ-015 SHALL ignore every cycle with VALID=0: no state, REF or counter change, and ERR=0.
REQ-016 In HUNT, on VALID with DIN!=0, SHALL set REF=next(DIN) and MCNT=1, then go to SYNC; DIN=0 (lock-up word) SHALL keep HUNT.
REQ-017 In SYNC, on VALID with DIN==REF, SHALL increment MCNT and set REF=next(DIN); when MCNT reaches LOCK_CNT it SHALL enter LOCKED, with MISS=0.
REQ-018 In SYNC, on VALID with DIN!=REF, SHALL reseed (REF=next(DIN), MCNT=1) if DIN!=0, else return to HUNT; no ERR and no count in SYNC.
REQ-019 In LOCKED, on VALID, SHALL always advance REF=next(REF) (flywheel; data never reseeds while locked).
REQ-020 In LOCKED, a mismatch SHALL pulse ERR on the next cycle, increment ERR_CNT (saturating at all-ones, no wrap) and increment MISS; a match SHALL clear MISS.
REQ-021 When MISS reaches LOSS_CNT, SHALL go to HUNT and pulse LOS; that word's ERR and ERR_CNT update SHALL still occur.
REQ-022 CLR SHALL zero ERR_CNT next cycle; if CLR coincides with a counted mismatch, CLR SHALL win (ERR_CNT=0) while ERR still pulses.
REQ-023 LOCKED SHALL be a registered decode of state; detection-to-ERR latency SHALL be exactly 1 cycle after the VALID edge.

Reset
REQ-024 RST_N=0 SHALL asynchronously force HUNT, REF=0, MCNT=0, MISS=0, LOCKED=0, ERR=0, LOS=0, ERR_CNT=0 (and BIT_ERR_CNT=0 when compiled in); release is synchronous to CLK.
REQ-025 Reset asserted mid-lock SHALL discard lock; re-lock SHALL require the full HUNT/SYNC sequence.

Configuration
REQ-026 Macro LFSR32_CHECKER_BITERR_EN, when defined, SHALL add output BIT_ERR_CNT[ERRW-1:0]: saturating sum of popcount(DIN^REF) over LOCKED mismatches, cleared by CLR/reset like ERR_CNT.
REQ-027 Without LFSR32_CHECKER_BITERR_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package lfsr32_pkg SHALL hold POLY=32'h80000923, width constant 32, the state enum (HUNT/SYNC/LOCKED) and function next32().
REQ-029 Sub-module lfsr32_popcnt (32-bit population count) SHALL be instantiated only under LFSR32_CHECKER_BITERR_EN; no other sub-modules.

Verification
REQ-030 Feed 00000001h, 80000000h, C0000000h, 60000000h (VALID=1, LOCK_CNT=4) -> LOCKED=1 one cycle after the 4th word; ERR never set.
REQ-031 In HUNT, drive DIN=00000000h for 10 cycles -> state remains HUNT, LOCKED=0.
REQ-032 Locked stream, one word with bit 0 flipped -> ERR pulses once, ERR_CNT=1, LOCKED stays 1, next correct word matches (flywheel) -> no further ERR.
REQ-033 Locked, then 8 consecutive random wrong words (LOSS_CNT=8) -> ERR_CNT=8, LOS pulses once with the 8th, LOCKED=0.
REQ-034 ERRW=4, 20 errors in lock with LOSS_CNT=255 -> ERR_CNT saturates at Fh; CLR together with a 21st error -> ERR_CNT=0, ERR=1.
REQ-035 Assert RST_N low mid-lock with VALID gaps interleaved -> all outputs 0 immediately, re-lock after exactly LOCK_CNT valid words.
